// File: rtl/buffer_serializer_pkg.sv
// Shared definitions for buffer_serializer: FSM state encoding and the
// constant functions that size the chunk counter.
package buffer_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  // Number of chunks per word; a zero chunk width is trapped by the top-level check.
  function automatic int unsigned calc_nchunk(input int unsigned word_size,
                                              input int unsigned chunk_size);
    return (chunk_size == 0) ? 1 : (word_size / chunk_size);
  endfunction

  // Counter width, never below one bit so NCHUNK=1 still has a legal vector.
  function automatic int unsigned calc_cnt_width(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/buffer_serializer_chunk_shifter.sv
// Loadable shift register holding one buffer word and presenting the chunk
// currently at the outgoing end.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data (takes priority over shift)
//   shift      : drop the presented chunk and move the next one into place
//   load_data  : word to capture
//   chunk      : current chunk (top bits if MSB_FIRST, else bottom bits)
module buffer_serializer_chunk_shifter #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned CHUNK_SIZE = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_SIZE-1:0]  load_data,
  output logic [CHUNK_SIZE-1:0] chunk
);

  logic [WORD_SIZE-1:0] word_q;
  logic [WORD_SIZE-1:0] word_d;

  // Shift direction follows the end the chunk is taken from.
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = load_data;
    end else if (shift) begin
      word_d = MSB_FIRST ? (word_q << CHUNK_SIZE) : (word_q >> CHUNK_SIZE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  if (MSB_FIRST) begin : g_msb
    assign chunk = word_q[WORD_SIZE-1 -: CHUNK_SIZE];
  end else begin : g_lsb
    assign chunk = word_q[CHUNK_SIZE-1:0];
  end

endmodule

// File: rtl/buffer_serializer.sv
// Drain stage for the circular word buffer: pops one word at a time and
// streams it out as WORD_SIZE/CHUNK_SIZE chunks on a valid/ready interface.
//   clk, rst  : clock, synchronous active-high reset
//   buf_empty : buffer empty flag (registered in the buffer)
//   buf_rd    : one-cycle pop request to the buffer
//   buf_data  : buffer data_out, valid the cycle after buf_rd
//   out_data  : current chunk
//   out_valid : chunk valid
//   out_ready : sink accepts the chunk when high with out_valid
//   out_last  : final chunk of a word
//   busy      : FSM is not idle
module buffer_serializer
  import buffer_serializer_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned CHUNK_SIZE = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_empty,
  output logic                  buf_rd,
  input  logic [WORD_SIZE-1:0]  buf_data,
  output logic [CHUNK_SIZE-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned      NCHUNK   = calc_nchunk(WORD_SIZE, CHUNK_SIZE);
  localparam int unsigned      CNT_W    = calc_cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  if ((CHUNK_SIZE == 0) || ((WORD_SIZE % CHUNK_SIZE) != 0)) begin : g_bad_chunk
    $error("buffer_serializer: CHUNK_SIZE must divide WORD_SIZE exactly");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buf_rd_q, buf_rd_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             load_c;
  logic             shift_c;

  // Next state; empty is only looked at in IDLE and on the last-chunk handshake,
  // both at least one cycle after the previous pop so the flag is current.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!buf_empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        load_c  = 1'b1;
        cnt_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          shift_c = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = buf_empty ? ST_IDLE : ST_REQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are the decode of the next state, so the flops mirror the state register.
    buf_rd_d    = (state_d == ST_REQ);
    out_valid_d = (state_d == ST_SEND);
    out_last_d  = (state_d == ST_SEND) && (cnt_d == CNT_LAST);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      buf_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_rd_q    <= buf_rd_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  buffer_serializer_chunk_shifter #(
    .WORD_SIZE  (WORD_SIZE),
    .CHUNK_SIZE (CHUNK_SIZE),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .shift     (shift_c),
    .load_data (buf_data),
    .chunk     (out_data)
  );

  assign buf_rd    = buf_rd_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_buffer_serializer.sv
// Directed bench for buffer_serializer: an MSB-first and an LSB-first
// instance share one small buffer model driven by the MSB instance's pops.
module tb_buffer_serializer;

  logic        clk;
  logic        rst;
  logic        buf_empty;
  logic [31:0] buf_data;
  logic        out_ready;

  logic        m_buf_rd, m_out_valid, m_out_last, m_busy;
  logic [7:0]  m_out_data;
  logic        l_buf_rd, l_out_valid, l_out_last, l_busy;
  logic [7:0]  l_out_data;

  logic [31:0] words [0:3];
  int          n_words;
  int          rd_ptr;

  int vectors = 0;
  int errors  = 0;

  buffer_serializer #(.WORD_SIZE(32), .CHUNK_SIZE(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_rd(m_buf_rd),
    .buf_data(buf_data), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_last(m_out_last), .busy(m_busy)
  );

  buffer_serializer #(.WORD_SIZE(32), .CHUNK_SIZE(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_rd(l_buf_rd),
    .buf_data(buf_data), .out_data(l_out_data), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_last(l_out_last), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: registered data_out and registered empty flag.
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= 0;
      buf_empty <= 1'b1;
      buf_data  <= '0;
    end else if (m_buf_rd) begin
      buf_data  <= words[rd_ptr[1:0]];
      rd_ptr    <= rd_ptr + 1;
      buf_empty <= (rd_ptr + 1 >= n_words);
    end else begin
      buf_empty <= (rd_ptr >= n_words);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; n_words = 0;
    tick();
    tick();
    vectors++; if (m_buf_rd !== 1'b0)     begin errors++; $display("FAIL reset_buf_rd: got %b want 0", m_buf_rd); end
    vectors++; if (m_out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid); end
    vectors++; if (m_out_last !== 1'b0)   begin errors++; $display("FAIL reset_out_last: got %b want 0", m_out_last); end
    vectors++; if (m_out_data !== 8'h00)  begin errors++; $display("FAIL reset_out_data: got %h want 00", m_out_data); end
    vectors++; if (m_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    vectors++; if (l_out_data !== 8'h00)  begin errors++; $display("FAIL reset_lsb_out_data: got %h want 00", l_out_data); end
    vectors++; if (l_out_valid !== 1'b0)  begin errors++; $display("FAIL reset_lsb_out_valid: got %b want 0", l_out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_msb_first();
    logic [7:0] exp [0:3];
    int k, rd_cnt, first_v, last_v;
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    words[0] = 32'hA1B2C3D4; n_words = 1; out_ready = 1'b1;
    apply_reset();
    k = 0; rd_cnt = 0; first_v = -1; last_v = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (m_buf_rd) rd_cnt++;
      if (m_out_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (k < 4) begin
          vectors++; if (m_out_data !== exp[k]) begin errors++; $display("FAIL msb_chunk%0d: got %h want %h", k, m_out_data, exp[k]); end
          vectors++; if (m_out_last !== 1'(k == 3)) begin errors++; $display("FAIL msb_last%0d: got %b want %b", k, m_out_last, (k == 3)); end
        end
        k++;
      end
    end
    vectors++; if (k != 4)       begin errors++; $display("FAIL msb_chunk_count: got %0d want 4", k); end
    vectors++; if (rd_cnt != 1)  begin errors++; $display("FAIL msb_rd_pulses: got %0d want 1", rd_cnt); end
    vectors++; if (first_v != 4) begin errors++; $display("FAIL msb_first_valid_cycle: got %0d want 4", first_v); end
    vectors++; if (last_v != 7)  begin errors++; $display("FAIL msb_last_valid_cycle: got %0d want 7", last_v); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp [0:3];
    int k, rd_cnt, first_v;
    exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    words[0] = 32'hA1B2C3D4; n_words = 1; out_ready = 1'b1;
    apply_reset();
    k = 0; rd_cnt = 0; first_v = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (l_buf_rd) rd_cnt++;
      if (l_out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (k < 4) begin
          vectors++; if (l_out_data !== exp[k]) begin errors++; $display("FAIL lsb_chunk%0d: got %h want %h", k, l_out_data, exp[k]); end
          vectors++; if (l_out_last !== 1'(k == 3)) begin errors++; $display("FAIL lsb_last%0d: got %b want %b", k, l_out_last, (k == 3)); end
        end
        k++;
      end
    end
    vectors++; if (k != 4)       begin errors++; $display("FAIL lsb_chunk_count: got %0d want 4", k); end
    vectors++; if (rd_cnt != 1)  begin errors++; $display("FAIL lsb_rd_pulses: got %0d want 1", rd_cnt); end
    vectors++; if (first_v != 4) begin errors++; $display("FAIL lsb_first_valid_cycle: got %0d want 4", first_v); end
  endtask

  task automatic test_backpressure();
    int rd_cnt;
    words[0] = 32'hA1B2C3D4; n_words = 1; out_ready = 1'b1;
    apply_reset();
    rd_cnt = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      if (m_buf_rd) rd_cnt++;
    end
    vectors++; if (m_out_data !== 8'hB2) begin errors++; $display("FAIL bp_b2_presented: got %h want b2", m_out_data); end
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (m_buf_rd) rd_cnt++;
      vectors++; if (m_out_data !== 8'hB2)  begin errors++; $display("FAIL bp_hold_data%0d: got %h want b2", i, m_out_data); end
      vectors++; if (m_out_valid !== 1'b1)  begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, m_out_valid); end
      vectors++; if (m_out_last !== 1'b0)   begin errors++; $display("FAIL bp_hold_last%0d: got %b want 0", i, m_out_last); end
      vectors++; if (l_out_data !== 8'hC3)  begin errors++; $display("FAIL bp_hold_lsb%0d: got %h want c3", i, l_out_data); end
    end
    out_ready = 1'b1;
    tick();
    if (m_buf_rd) rd_cnt++;
    vectors++; if (m_out_data !== 8'hC3) begin errors++; $display("FAIL bp_c3_after: got %h want c3", m_out_data); end
    vectors++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL bp_c3_valid: got %b want 1", m_out_valid); end
    tick();
    if (m_buf_rd) rd_cnt++;
    vectors++; if (m_out_data !== 8'hD4) begin errors++; $display("FAIL bp_d4_after: got %h want d4", m_out_data); end
    vectors++; if (m_out_last !== 1'b1)  begin errors++; $display("FAIL bp_d4_last: got %b want 1", m_out_last); end
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (m_buf_rd) rd_cnt++;
    end
    vectors++; if (rd_cnt != 1)  begin errors++; $display("FAIL bp_rd_pulses: got %0d want 1", rd_cnt); end
    vectors++; if (m_busy !== 1'b0) begin errors++; $display("FAIL bp_idle_after: got %b want 0", m_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [0:7];
    int rd_cyc [0:3];
    int k, rd_cnt, busy_low;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    words[0] = 32'h11223344; words[1] = 32'h55667788; n_words = 2; out_ready = 1'b1;
    apply_reset();
    k = 0; rd_cnt = 0; busy_low = 0;
    for (int i = 0; i < 4; i++) rd_cyc[i] = -1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      if (m_buf_rd) begin
        if (rd_cnt < 4) rd_cyc[rd_cnt] = cyc;
        rd_cnt++;
      end
      if (cyc >= 2 && cyc <= 13 && !m_busy) busy_low++;
      if (m_out_valid) begin
        if (k < 8) begin
          vectors++; if (m_out_data !== exp[k]) begin errors++; $display("FAIL b2b_chunk%0d: got %h want %h", k, m_out_data, exp[k]); end
          vectors++; if (m_out_last !== 1'(k == 3 || k == 7)) begin errors++; $display("FAIL b2b_last%0d: got %b want %b", k, m_out_last, (k == 3 || k == 7)); end
        end
        k++;
      end
    end
    vectors++; if (k != 8)         begin errors++; $display("FAIL b2b_chunk_count: got %0d want 8", k); end
    vectors++; if (rd_cnt != 2)    begin errors++; $display("FAIL b2b_rd_pulses: got %0d want 2", rd_cnt); end
    vectors++; if (rd_cyc[0] != 2) begin errors++; $display("FAIL b2b_first_rd_cycle: got %0d want 2", rd_cyc[0]); end
    vectors++; if (rd_cyc[1] != 8) begin errors++; $display("FAIL b2b_second_rd_cycle: got %0d want 8", rd_cyc[1]); end
    vectors++; if (busy_low != 0)  begin errors++; $display("FAIL b2b_busy_drop: got %0d low cycles want 0", busy_low); end
    vectors++; if (m_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b want 0", m_busy); end
  endtask

  task automatic test_empty_idle();
    n_words = 0; out_ready = 1'b1;
    apply_reset();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      vectors++; if (m_buf_rd !== 1'b0)    begin errors++; $display("FAIL empty_rd%0d: got %b want 0", cyc, m_buf_rd); end
      vectors++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid%0d: got %b want 0", cyc, m_out_valid); end
      vectors++; if (m_busy !== 1'b0)      begin errors++; $display("FAIL empty_busy%0d: got %b want 0", cyc, m_busy); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [0:3];
    int k, rd_cnt, first_v;
    exp = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    words[0] = 32'hA1B2C3D4; n_words = 1; out_ready = 1'b1;
    apply_reset();
    for (int cyc = 1; cyc <= 5; cyc++) tick();
    vectors++; if (m_out_data !== 8'hB2) begin errors++; $display("FAIL rmw_second_chunk: got %h want b2", m_out_data); end
    rst = 1'b1;
    words[0] = 32'hCAFEBABE;
    tick();
    vectors++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid: got %b want 0", m_out_valid); end
    vectors++; if (m_busy !== 1'b0)      begin errors++; $display("FAIL rmw_busy: got %b want 0", m_busy); end
    vectors++; if (m_buf_rd !== 1'b0)    begin errors++; $display("FAIL rmw_rd: got %b want 0", m_buf_rd); end
    vectors++; if (m_out_last !== 1'b0)  begin errors++; $display("FAIL rmw_last: got %b want 0", m_out_last); end
    vectors++; if (m_out_data !== 8'h00) begin errors++; $display("FAIL rmw_data: got %h want 00", m_out_data); end
    vectors++; if (l_out_data !== 8'h00) begin errors++; $display("FAIL rmw_lsb_data: got %h want 00", l_out_data); end
    rst = 1'b0;
    k = 0; rd_cnt = 0; first_v = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (m_buf_rd) rd_cnt++;
      if (m_out_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          vectors++; if (l_out_data !== 8'hBE) begin errors++; $display("FAIL rmw_lsb_first: got %h want be", l_out_data); end
        end
        if (k < 4) begin
          vectors++; if (m_out_data !== exp[k]) begin errors++; $display("FAIL rmw_chunk%0d: got %h want %h", k, m_out_data, exp[k]); end
        end
        k++;
      end
    end
    vectors++; if (first_v != 4) begin errors++; $display("FAIL rmw_first_valid_cycle: got %0d want 4", first_v); end
    vectors++; if (k != 4)       begin errors++; $display("FAIL rmw_chunk_count: got %0d want 4", k); end
    vectors++; if (rd_cnt != 1)  begin errors++; $display("FAIL rmw_rd_pulses: got %0d want 1", rd_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    n_words = 0;
    for (int i = 0; i < 4; i++) words[i] = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_empty_idle();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/buffer_serializer.md
Name: buffer_serializer

Overview:
Downstream drain stage for the circular word buffer. It watches the buffer's empty flag, pulses the buffer's rd input to pop one word, and captures the word from the buffer's registered data_out. It then emits the word as WORD_SIZE/CHUNK_SIZE narrow chunks on a valid/ready stream toward a byte- or nibble-wide sink, such as a UART/SPI transmitter.

Parameters:
WORD_SIZE, 32, width of buffer words; must equal the buffer's word_size.
CHUNK_SIZE, 8, width of each output chunk; must divide WORD_SIZE exactly (elaboration-time check).
MSB_FIRST, 1, 1 = most-significant chunk sent first; 0 = least-significant chunk first.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
buf_empty  input  1  buffer empty flag (registered in buffer).
buf_rd  output  1  one-cycle pop request to buffer.
buf_data  input  WORD_SIZE  buffer data_out; valid in the cycle after buf_rd.
out_data  output  CHUNK_SIZE  current chunk.
out_valid  output  1  chunk valid.
out_ready  input  1  sink accepts chunk when high together with out_valid.
out_last  output  1  high with the final chunk of a word.
busy  output  1  high in any state other than IDLE.

Behaviour:
- NCHUNK = WORD_SIZE/CHUNK_SIZE. Chunk counter width is clog2(NCHUNK), minimum 1.
- FSM states and transitions:
  - IDLE: if !buf_empty, go to REQ.
  - REQ: buf_rd=1 for exactly this cycle; go to CAPT.
  - CAPT: buf_data now holds the popped word; load it into the shift register at the end of the cycle; clear counter; go to SEND.
  - SEND: out_valid=1. On out_valid && out_ready, advance the shift register by CHUNK_SIZE and increment the counter. On the handshake of the last chunk: go to REQ if !buf_empty, else go to IDLE.
- Output decode:
  - buf_rd, out_valid and out_last are decoded from state/counter only; none has a combinational path from out_ready.
  - out_last = SEND && counter == NCHUNK-1.
  - out_data = top CHUNK_SIZE bits of the shift register when MSB_FIRST=1, bottom CHUNK_SIZE bits when MSB_FIRST=0; shift direction matches.
- Backpressure: while out_valid && !out_ready, out_data, out_last and the counter hold stable.
- Read-request rule:
  - Exactly one buf_rd pulse per word.
  - buf_rd is never asserted in two consecutive cycles.
  - buf_empty is sampled only in IDLE or at the last-chunk handshake. Both points are at least one cycle after the previous pop, so the buffer's registered empty flag is current.
- Throughput: with out_ready held high, one word every NCHUNK+2 cycles (REQ, CAPT, NCHUNK x SEND).
- Latency: first out_valid occurs 3 cycles after buf_empty falls in IDLE (IDLE -> REQ -> CAPT -> SEND).
- Reset values: state IDLE, buf_rd=0, out_valid=0, out_last=0, out_data=0, shift register=0, counter=0, busy=0.
- Reset mid-word: remaining chunks are discarded and the popped word is lost. A reset asserted in REQ still leaves the buffer seeing rd that cycle; the buffer must be reset alongside.
- buf_empty rising while in SEND has no effect on the word in flight.
- NCHUNK=1 (CHUNK_SIZE=WORD_SIZE) is legal; out_last is then high on every chunk.

Decomposition:
- Shared package: FSM state encoding (IDLE, REQ, CAPT, SEND, 2 bits); NCHUNK and counter-width constant functions.
- One natural sub-module: chunk_shifter, a loadable shift register with parameterised direction, holding the word and presenting the current chunk. The FSM and counter stay in buffer_serializer.

Test Plan:
1. buf_empty=0 with buf_data=0xA1B2C3D4, MSB_FIRST=1, out_ready=1 -> out_data A1,B2,C3,D4 on 4 consecutive cycles; out_last only on D4; one buf_rd pulse.
2. Same word, MSB_FIRST=0 -> chunks D4,C3,B2,A1; out_last on A1.
3. out_ready low for 5 cycles while B2 is presented -> B2 and out_valid held stable for 5 cycles; C3 follows on the first cycle with ready high; no extra buf_rd.
4. Two words queued (0x11223344, 0x55667788), buf_empty low throughout, ready=1 -> buf_rd pulses exactly 6 cycles apart; 8 chunks in order; busy stays high; FSM goes to REQ directly after the first word's last chunk.
5. buf_empty held high for 20 cycles -> buf_rd=0, out_valid=0, busy=0 throughout.
6. rst asserted on the 2nd chunk of a word -> next cycle out_valid=0, state IDLE, all outputs zero. After release with buf_empty=0, a new REQ starts and the next word begins with its first chunk.
